// File: rtl/imu_spi_sequencer.sv
// IMU SPI sequencer: register-write init list, then one burst read per data-ready
// interrupt, packed with its capture timestamp into an AXI-Stream frame.
// Optional overrun counter enabled by defining IMU_SEQ_OVERRUN_CNT_EN.
module imu_spi_sequencer #(
  parameter int         C_M_AXIS_TDATA_WIDTH = 32,
  parameter int         TIMESTAMP_WIDTH      = 64,
  parameter int         BURST_BYTES          = 12,
  parameter logic [7:0] READ_ADDR            = 8'h1F,
  parameter logic [7:0] INIT_ADDR0           = 8'h06,
  parameter logic [7:0] INIT_DATA0           = 8'h01,
  parameter logic [7:0] INIT_ADDR1           = 8'h0F,
  parameter logic [7:0] INIT_DATA1           = 8'h01
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            run,
  input  logic                            imu_int,
  input  logic [TIMESTAMP_WIDTH-1:0]      timestamp,
  output logic                            spi_start,
  output logic [7:0]                      spi_tx_byte,
  output logic                            spi_cs_hold,
  input  logic                            spi_busy,
  input  logic                            spi_done,
  input  logic [7:0]                      spi_rx_byte,
  output logic                            m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [15:0]                     overrun_count,
  output logic                            busy
);

  localparam int NWORDS      = BURST_BYTES / 4;
  localparam int FRAME_WORDS = NWORDS + 2;
  localparam int WIDX        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW          = WIDX + 2;

  typedef enum logic [2:0] {IDLE, INIT, WAIT_INT, RD_CMD, RD_DATA, EMIT} state_t;

  state_t          state;
  logic            int_meta, int_sync, int_sync_q, int_event;
  logic            run_q;
  logic            xfer_wait;
  logic [1:0]      init_idx;
  logic [CW-1:0]   byte_cnt;
  logic [3:0]      word_idx;
  logic [3:0]      buf_sel;
  logic [31:0]     emit_next;
  logic [TIMESTAMP_WIDTH-1:0] ts_q;
  logic [3:0][7:0] buf_mem [NWORDS];

  wire can_issue = !xfer_wait && !spi_busy && !spi_done && !spi_start;
  wire last_byte = (byte_cnt == CW'(BURST_BYTES - 1));

  assign busy = !(state == IDLE || state == WAIT_INT);

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return {1'b0, INIT_ADDR0[6:0]};
      2'd1:    return INIT_DATA0;
      2'd2:    return {1'b0, INIT_ADDR1[6:0]};
      default: return INIT_DATA1;
    endcase
  endfunction

  // The registered edge detect places the int event three cycles after imu_int rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta   <= 1'b0;
      int_sync   <= 1'b0;
      int_sync_q <= 1'b0;
      int_event  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      int_meta   <= imu_int;
      int_sync   <= int_meta;
      int_sync_q <= int_sync;
      int_event  <= int_sync & ~int_sync_q;
      run_q      <= run;
    end
  end

  // NOTE: the burst buffer has no reset; every word is rewritten before EMIT reads it.
  always_ff @(posedge clk) begin
    if (state == RD_DATA && xfer_wait && spi_done)
      buf_mem[byte_cnt[CW-1:2]][byte_cnt[1:0]] <= spi_rx_byte;
  end

  // NOTE: always_comb gives every output a default first, so no latch is inferred.
  always_comb begin
    emit_next = ts_q[63:32];
    buf_sel   = word_idx - 4'd1;
    if (word_idx != 4'd0)
      emit_next = buf_mem[buf_sel[WIDX-1:0]];
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      xfer_wait     <= 1'b0;
      init_idx      <= '0;
      byte_cnt      <= '0;
      word_idx      <= '0;
      ts_q          <= '0;
      spi_start     <= 1'b0;
      spi_tx_byte   <= 8'h00;
      spi_cs_hold   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      if (spi_done)
        xfer_wait <= 1'b0;

      case (state)
        IDLE: begin
          if (run && !run_q) begin
            state    <= INIT;
            init_idx <= '0;
          end
        end

        INIT: begin
          if (can_issue) begin
            spi_start   <= 1'b1;
            spi_tx_byte <= init_byte(init_idx);
            spi_cs_hold <= ~init_idx[0];
            xfer_wait   <= 1'b1;
          end else if (xfer_wait && spi_done) begin
            init_idx <= init_idx + 2'd1;
            if (init_idx == 2'd3)
              state <= WAIT_INT;
          end
        end

        WAIT_INT: begin
          if (!run) begin
            state <= IDLE;
          end else if (int_event) begin
            ts_q  <= timestamp;
            state <= RD_CMD;
            if (can_issue) begin
              spi_start   <= 1'b1;
              spi_tx_byte <= {1'b1, READ_ADDR[6:0]};
              spi_cs_hold <= 1'b1;
              xfer_wait   <= 1'b1;
            end
          end
        end

        RD_CMD: begin
          if (can_issue) begin
            spi_start   <= 1'b1;
            spi_tx_byte <= {1'b1, READ_ADDR[6:0]};
            spi_cs_hold <= 1'b1;
            xfer_wait   <= 1'b1;
          end else if (xfer_wait && spi_done) begin
            state    <= RD_DATA;
            byte_cnt <= '0;
          end
        end

        RD_DATA: begin
          if (can_issue) begin
            spi_start   <= 1'b1;
            spi_tx_byte <= 8'h00;
            spi_cs_hold <= !last_byte;
            xfer_wait   <= 1'b1;
          end else if (xfer_wait && spi_done) begin
            if (last_byte) begin
              state         <= EMIT;
              word_idx      <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= ts_q[31:0];
              m_axis_tlast  <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end

        EMIT: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
              state         <= WAIT_INT;
            end else begin
              word_idx     <= word_idx + 4'd1;
              m_axis_tdata <= emit_next;
              m_axis_tlast <= (word_idx == 4'(FRAME_WORDS - 2));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMU_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      overrun_count <= 16'h0000;
    else if (int_event && state != WAIT_INT && overrun_count != 16'hFFFF)
      overrun_count <= overrun_count + 16'd1;
  end
`else
  assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_imu_spi_sequencer.sv
// Self-checking bench for imu_spi_sequencer: SPI engine model, stream scoreboard,
// table of burst frames plus hand-written overrun, run-drop and reset sequences.
module tb_imu_spi_sequencer;

  logic        clk = 1'b0;
  logic        resetn, run, imu_int;
  logic [63:0] timestamp;
  logic        spi_start, spi_cs_hold, spi_busy, spi_done;
  logic [7:0]  spi_tx_byte, spi_rx_byte;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [15:0] overrun_count;
  logic        busy;

  imu_spi_sequencer dut (
    .clk(clk), .resetn(resetn), .run(run), .imu_int(imu_int), .timestamp(timestamp),
    .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_cs_hold(spi_cs_hold),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_byte(spi_rx_byte),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .overrun_count(overrun_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0]  miso_q[$];
  logic [8:0]  mosi_q[$];
  int          start_cyc_q[$];
  logic [32:0] exp_q[$];
  int          words_seen = 0;
  int          stalls_seen = 0;
  int          int_cyc = 0;
  bit          stall_mode = 1'b0;

`ifdef IMU_SEQ_OVERRUN_CNT_EN
  localparam int OV_INC = 1;
`else
  localparam int OV_INC = 0;
`endif
  int exp_ov = 0;

  // SPI byte engine: 8 busy cycles then a one-cycle done carrying the next MISO byte.
  initial begin
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (spi_start === 1'b1) begin
        mosi_q.push_back({spi_cs_hold, spi_tx_byte});
        start_cyc_q.push_back(cyc);
        spi_busy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        spi_busy = 1'b0;
        spi_done = 1'b1;
        spi_rx_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
      end
    end
  end

  // Sink ready: always high, or the 1,0,0,1 pattern while stall_mode is set.
  initial begin
    logic pat [4];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_mode) begin
        m_axis_tready = pat[k % 4];
        k++;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // Stream monitor: a beat transfers at the posedge following a negedge with valid & ready.
  initial begin
    bit          stall_prev;
    logic [32:0] stall_word;
    logic [32:0] w;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (stall_prev && resetn) begin
        check("stall_tvalid_held", 64'(m_axis_tvalid), 64'd1);
        check("stall_data_stable", 64'({m_axis_tlast, m_axis_tdata}), 64'(stall_word));
      end
      stall_prev = resetn && m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tlast, m_axis_tdata};
      if (stall_prev) stalls_seen++;
      if (resetn && m_axis_tvalid && m_axis_tready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word", {m_axis_tlast, m_axis_tdata});
        end else begin
          w = exp_q.pop_front();
          check("frame_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(w));
        end
      end
    end
  end

  function automatic logic [31:0] burst_word(input logic [7:0] base, input int k);
    logic [7:0] x;
    x = base + 8'(4 * k);
    return {x + 8'd3, x + 8'd2, x + 8'd1, x};
  endfunction

  task automatic pulse_int();
    @(posedge clk); #1;
    imu_int = 1'b1;
    int_cyc = cyc;
    repeat (4) @(posedge clk);
    #1;
    imu_int = 1'b0;
  endtask

  task automatic wait_idle(input int n_mosi, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (mosi_q.size() >= n_mosi) && (exp_q.size() == 0) && !busy && !spi_busy;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got mosi=%0d pending=%0d expected mosi=%0d pending=0",
               name, mosi_q.size(), exp_q.size(), n_mosi);
    end
  endtask

  task automatic wait_mosi(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (mosi_q.size() >= n);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_mosi_timeout: got %0d expected %0d", mosi_q.size(), n);
    end
  endtask

  task automatic load_frame(input logic [63:0] ts, input logic [7:0] base, input logic [31:0] w0,
                            input bit expect_out);
    timestamp = ts;
    miso_q.push_back(8'hA5);
    for (int b = 0; b < 12; b++) miso_q.push_back(base + 8'(b));
    if (expect_out) begin
      exp_q.push_back({1'b0, ts[31:0]});
      exp_q.push_back({1'b0, ts[63:32]});
      exp_q.push_back({1'b0, w0});
      exp_q.push_back({1'b0, burst_word(base, 1)});
      exp_q.push_back({1'b1, burst_word(base, 2)});
    end
  endtask

  task automatic check_burst_mosi();
    check("mosi_count", 64'(mosi_q.size()), 64'd13);
    if (mosi_q.size() >= 13) begin
      check("mosi_read_cmd", 64'(mosi_q[0]), 64'({1'b1, 8'h9F}));
      for (int i = 1; i < 13; i++)
        check("mosi_dummy", 64'(mosi_q[i]), 64'({(i != 12), 8'h00}));
    end
  endtask

  typedef struct {
    logic [63:0] ts;
    logic [7:0]  miso_base;
    bit          stall;
    logic [31:0] exp_w0;
  } vec_t;

  initial begin
    vec_t       vecs [3];
    logic [8:0] exp_init [4];
    int         ws;

    vecs[0] = '{ts: 64'h0000_0001_0000_0010, miso_base: 8'h01, stall: 1'b0, exp_w0: 32'h0403_0201};
    vecs[1] = '{ts: 64'hDEAD_BEEF_0BAD_F00D, miso_base: 8'h40, stall: 1'b1, exp_w0: 32'h4342_4140};
    vecs[2] = '{ts: 64'h1234_5678_9ABC_DEF0, miso_base: 8'hF0, stall: 1'b0, exp_w0: 32'hF3F2_F1F0};
    exp_init = '{{1'b1, 8'h06}, {1'b0, 8'h01}, {1'b1, 8'h0F}, {1'b0, 8'h01}};

    resetn = 1'b0;
    run = 1'b0;
    imu_int = 1'b0;
    timestamp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spi_start",   64'(spi_start),     64'd0);
    check("rst_spi_tx_byte", 64'(spi_tx_byte),   64'd0);
    check("rst_spi_cs_hold", 64'(spi_cs_hold),   64'd0);
    check("rst_tvalid",      64'(m_axis_tvalid), 64'd0);
    check("rst_tdata",       64'(m_axis_tdata),  64'd0);
    check("rst_tlast",       64'(m_axis_tlast),  64'd0);
    check("rst_overrun",     64'(overrun_count), 64'd0);
    check("rst_busy",        64'(busy),          64'd0);

    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    wait_idle(4, "init");
    check("init_count", 64'(mosi_q.size()), 64'd4);
    if (mosi_q.size() >= 4)
      for (int i = 0; i < 4; i++) check("init_mosi", 64'(mosi_q[i]), 64'(exp_init[i]));
    check("init_wait_int_busy", 64'(busy), 64'd0);

    // Table of burst frames.
    for (int v = 0; v < 3; v++) begin
      mosi_q.delete();
      start_cyc_q.delete();
      load_frame(vecs[v].ts, vecs[v].miso_base, vecs[v].exp_w0, 1'b1);
      stall_mode = vecs[v].stall;
      pulse_int();
      wait_idle(13, "frame");
      stall_mode = 1'b0;
      check_burst_mosi();
      if (start_cyc_q.size() != 0)
        check("int_to_start_latency", 64'(start_cyc_q[0] - int_cyc), 64'd4);
    end
    check("stalls_exercised", 64'(stalls_seen > 0), 64'd1);

    // Second interrupt during RD_DATA is dropped.
    mosi_q.delete();
    ws = words_seen;
    load_frame(64'h0000_00AB_CDEF_0123, 8'h20, 32'h2322_2120, 1'b1);
    pulse_int();
    wait_mosi(4);
    pulse_int();
    exp_ov += OV_INC;
    wait_idle(13, "overrun");
    repeat (100) @(posedge clk);
    #1;
    check("overrun_one_frame", 64'(words_seen - ws), 64'd5);
    check("overrun_mosi", 64'(mosi_q.size()), 64'd13);
    check("overrun_count", 64'(overrun_count), 64'(exp_ov));

    // run dropped mid-burst: frame completes, then IDLE ignores interrupts.
    mosi_q.delete();
    ws = words_seen;
    load_frame(64'h0000_0000_5555_AAAA, 8'h80, 32'h8382_8180, 1'b1);
    pulse_int();
    wait_mosi(4);
    run = 1'b0;
    wait_idle(13, "run_drop");
    repeat (20) @(posedge clk);
    #1;
    check("run_drop_words", 64'(words_seen - ws), 64'd5);
    check_burst_mosi();
    check("run_drop_idle", 64'(busy), 64'd0);
    mosi_q.delete();
    pulse_int();
    exp_ov += OV_INC;
    repeat (60) @(posedge clk);
    #1;
    check("idle_no_spi", 64'(mosi_q.size()), 64'd0);
    check("idle_overrun", 64'(overrun_count), 64'(exp_ov));

    // Reset mid-burst: outputs clear at once and the partial frame never appears.
    run = 1'b1;
    wait_idle(4, "reinit");
    ws = words_seen;
    load_frame(64'h0000_0000_0000_0BAD, 8'h10, 32'h1312_1110, 1'b0);
    pulse_int();
    wait_mosi(6);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_tvalid",    64'(m_axis_tvalid), 64'd0);
    check("rst_mid_spi_start", 64'(spi_start),     64'd0);
    check("rst_mid_busy",      64'(busy),          64'd0);
    check("rst_mid_overrun",   64'(overrun_count), 64'd0);
    exp_ov = 0;
    repeat (20) @(posedge clk);
    #1;
    miso_q.delete();
    mosi_q.delete();
    resetn = 1'b1;
    wait_idle(4, "post_reset_init");
    repeat (150) @(posedge clk);
    #1;
    check("post_reset_no_frame", 64'(words_seen - ws), 64'd0);
    check("post_reset_init_only", 64'(mosi_q.size()), 64'd4);
    check("post_reset_overrun", 64'(overrun_count), 64'(exp_ov));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/imu_spi_sequencer.md
# imu_spi_sequencer

Sequences all SPI traffic to the IMU. After `run` rises it issues a fixed register-write init list, then on every data-ready interrupt it runs one burst register read. Each burst is packed with a capture timestamp into one AXI-Stream frame. It sits between the IMU interrupt/timestamp sources, a byte-level SPI engine (which owns the SPI pins) and the AXI-Stream sink feeding the DMA.

## Interface
- `C_M_AXIS_TDATA_WIDTH`, 32: stream width; only 32 is supported.
- `TIMESTAMP_WIDTH`, 64: timestamp width; fixed at 64.
- `BURST_BYTES`, 12: bytes per burst read; must be a multiple of 4, from 4 to 32.
- `READ_ADDR`, 8'h1F: first register of the burst.
- `INIT_ADDR0`, 8'h06 / `INIT_DATA0`, 8'h01: first init write.
- `INIT_ADDR1`, 8'h0F / `INIT_DATA1`, 8'h01: second init write.
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  level enable.
- `imu_int`  in  1  asynchronous data-ready line from the IMU, active high.
- `timestamp`  in  64  free-running counter in the `clk` domain.
- `spi_start`  out  1  one-cycle pulse that starts one byte transfer.
- `spi_tx_byte`  out  8  byte to shift out; held stable while `spi_busy`.
- `spi_cs_hold`  out  1  keeps CS asserted after the current byte.
- `spi_busy`  in  1  the SPI engine is transferring.
- `spi_done`  in  1  one-cycle pulse; `spi_rx_byte` is valid in that cycle.
- `spi_rx_byte`  in  8  received byte.
- `m_axis_tvalid`, `m_axis_tdata[31:0]`, `m_axis_tlast`  out: stream master outputs.
- `m_axis_tready`  in: stream master input.
- `overrun_count`  out  16  number of dropped interrupts.
- `busy`  out  1  high in any state other than IDLE or WAIT_INT.

## Operation
- `imu_int` passes through a 2-FF synchronizer, then rising-edge detection. The cycle in which the edge is detected is the "int event".
- FSM states: IDLE, INIT, WAIT_INT, RD_CMD, RD_DATA, EMIT.
- IDLE: entered from reset. A rising edge of `run` moves the FSM to INIT.
- INIT: performs two transactions, each two bytes:
  - first write: `{0,INIT_ADDR0[6:0]}` with `spi_cs_hold`=1, then `INIT_DATA0` with `spi_cs_hold`=0;
  - second write: the same pattern with `INIT_ADDR1`/`INIT_DATA1`;
  - then go to WAIT_INT.
- WAIT_INT:
  - if `run`=0, go to IDLE;
  - else an int event latches `timestamp` and goes to RD_CMD.
- RD_CMD: sends `{1,READ_ADDR[6:0]}` with `spi_cs_hold`=1. The received byte is discarded.
- RD_DATA: sends `BURST_BYTES` dummy bytes of 8'h00.
  - `spi_cs_hold`=1 on all bytes except the last.
  - Received bytes are packed little-endian: the first byte goes to word0[7:0].
  - Words are held in a buffer of `BURST_BYTES`/4 words.
- EMIT: streams the frame, then goes to WAIT_INT. The frame is, in order:
  - ts[31:0];
  - ts[63:32];
  - buffer word0 through word(`BURST_BYTES`/4-1), with `tlast` on the final word.
- `spi_start` is issued only when `spi_busy`=0 and no `spi_done` is pending. The next byte starts at the earliest one cycle after `spi_done`.
- An int event in any state other than WAIT_INT is dropped and increments `overrun_count`. The count saturates at 16'hFFFF and clears only on reset.
- When `run` falls mid-frame, the current frame still completes (including EMIT). Only then does the FSM return to IDLE, via WAIT_INT.
- A `run` rising edge seen outside IDLE is ignored.

## Timing
- Reset values: `spi_start`=0, `spi_tx_byte`=0, `spi_cs_hold`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `overrun_count`=0, `busy`=0. FSM is in IDLE and the synchronizer is cleared.
- Int event latency: 3 `clk` cycles from an `imu_int` rise meeting setup. The timestamp captured is the value in the int-event cycle.
- First `spi_start` in RD_CMD: 1 cycle after the int event.
- Stream handshake:
  - `tvalid` is registered;
  - data and `tlast` are held stable until `tvalid` and `tready` are both high;
  - `tvalid` never drops without a transfer;
  - with `tready` held high, back-to-back words go out at one per cycle.
- First EMIT word: 1 cycle after the last `spi_done`.
- Asserting reset mid-transaction aborts immediately. All outputs go to their reset values, and a partial frame is never emitted.

## Configuration
- With `IMU_SEQ_OVERRUN_CNT_EN` defined, `overrun_count` counts as described above.
- Without it, `overrun_count` is constant 0, the counter logic is removed, and dropped interrupts are silently discarded.

## Test plan
- Reset, then `run`=1 with an SPI model answering after 8 cycles:
  - required MOSI byte sequence is 06,01,0F,01;
  - `spi_cs_hold` pattern is 1,0,1,0;
  - FSM reaches WAIT_INT.
- `imu_int` pulse with `timestamp`=64'h0000_0001_0000_0010 and MISO bytes 01..0C:
  - frame is 00000010, 00000001, 04030201, 08070605, 0C0B0A09;
  - `tlast` is on word 5 only;
  - MOSI is 9F followed by 12×00.
- `tready` toggling 1,0,0,1 during EMIT: no word is lost or duplicated, and data stays stable while stalled.
- Second `imu_int` during RD_DATA:
  - `overrun_count`=1 and exactly one frame is emitted;
  - without the macro, `overrun_count`=0.
- `run` dropped during RD_DATA: the full frame is still emitted, then the FSM returns to IDLE, and a later `imu_int` produces no SPI activity.
- `resetn` asserted mid-burst: `m_axis_tvalid` and `spi_start` are 0 immediately, and after release no stale frame appears.
